// File: rtl/wb_dest_pipe_if.sv
// Decode-to-writeback destination channel: input select, writeback handshake,
// hazard queries and occupancy report.
interface wb_dest_pipe_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] C0;
    logic [ADDR_W-1:0] C1;
    logic [1:0]        S0;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_we;
    logic [ADDR_W-1:0] rs_q;
    logic [ADDR_W-1:0] rt_q;
    logic              rs_hazard;
    logic              rt_hazard;
    logic [CNT_W-1:0]  occupancy;

    // Decode/writeback side
    modport master (
        output in_valid, C0, C1, S0, wb_ready, rs_q, rt_q,
        input  in_ready, wb_valid, wb_addr, wb_we, rs_hazard, rt_hazard, occupancy
    );

    // Pipeline side
    modport slave (
        input  in_valid, C0, C1, S0, wb_ready, rs_q, rt_q,
        output in_ready, wb_valid, wb_addr, wb_we, rs_hazard, rt_hazard, occupancy
    );
endinterface

// File: rtl/wb_dest_pipe.sv
// Register-write destination select followed by a DEPTH-stage lockstep
// valid/ready pipeline to writeback, with RAW hazard and occupancy reporting.
module wb_dest_pipe #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned LINK_ADDR = 31,
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned CNT_W     = 4
) (
    input  logic          clk,
    input  logic          rst,
    wb_dest_pipe_if.slave bus
);
    typedef struct packed {
        logic              vld;
        logic              we;
        logic [ADDR_W-1:0] addr;
    } stage_t;

    // Elaboration-time guard on the legal parameter range
    if (DEPTH < 1 || DEPTH > 8 || (1 << CNT_W) <= DEPTH) begin : g_param_check
        $error("wb_dest_pipe: DEPTH must be 1..8 and 2**CNT_W > DEPTH");
    end

    stage_t             stg [DEPTH];
    stage_t             in_stage_c;
    logic [ADDR_W-1:0]  sel_addr_c;
    logic               advance_c;
    logic               accept_c;
    logic               emit_c;
    logic               rs_haz_c;
    logic               rt_haz_c;
    logic [CNT_W-1:0]   occ_q;

    // Destination select; bubbles carry addr 0 / we 0 so idle outputs read zero
    always_comb begin
        sel_addr_c = '0;
        in_stage_c = '0;
        case (bus.S0)
            2'b00:   sel_addr_c = bus.C0;
            2'b01:   sel_addr_c = bus.C1;
            2'b10:   sel_addr_c = ADDR_W'(LINK_ADDR);
            default: sel_addr_c = '0;
        endcase
        if (bus.in_valid) begin
            in_stage_c.vld  = 1'b1;
            in_stage_c.addr = sel_addr_c;
            in_stage_c.we   = (bus.S0 != 2'b11) && (sel_addr_c != '0);
        end
    end

    assign advance_c = !stg[DEPTH-1].vld || bus.wb_ready;
    assign accept_c  = bus.in_valid && advance_c;
    assign emit_c    = stg[DEPTH-1].vld && bus.wb_ready;

    // Lockstep shift: every stage moves together or everything holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stg[k] <= '0;
            end
        end else if (advance_c) begin
            stg[0] <= in_stage_c;
            for (int k = 1; k < int'(DEPTH); k++) begin
                stg[k] <= stg[k-1];
            end
        end
    end

    // Occupancy tracks accepts minus emits; simultaneous accept+emit cancels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            case ({accept_c, emit_c})
                2'b10:   occ_q <= occ_q + CNT_W'(1);
                2'b01:   occ_q <= occ_q - CNT_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // RAW hazard against every pending write, including the one on wb_*
    always_comb begin
        rs_haz_c = 1'b0;
        rt_haz_c = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (stg[k].vld && stg[k].we) begin
                if (stg[k].addr == bus.rs_q) rs_haz_c = 1'b1;
                if (stg[k].addr == bus.rt_q) rt_haz_c = 1'b1;
            end
        end
        if (bus.rs_q == '0) rs_haz_c = 1'b0;
        if (bus.rt_q == '0) rt_haz_c = 1'b0;
    end

    assign bus.in_ready  = advance_c;
    assign bus.wb_valid  = stg[DEPTH-1].vld;
    assign bus.wb_addr   = stg[DEPTH-1].addr;
    assign bus.wb_we     = stg[DEPTH-1].we;
    assign bus.rs_hazard = rs_haz_c;
    assign bus.rt_hazard = rt_haz_c;
    assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_wb_dest_pipe.sv
// Directed bench for wb_dest_pipe: slot-queue reference model compared every
// cycle, plus hand-computed literal checks for each scenario.
module tb_wb_dest_pipe;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LINK   = 31;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_dest_pipe_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    wb_dest_pipe #(
        .ADDR_W(ADDR_W), .LINK_ADDR(LINK), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference model: a queue of DEPTH slots, index 0 = newest, last = wb output
    typedef struct {
        bit v;
        int a;
        bit w;
    } slot_t;
    slot_t m[$];

    function automatic void m_clear();
        slot_t z;
        z = '{v: 1'b0, a: 0, w: 1'b0};
        m.delete();
        for (int i = 0; i < int'(DEPTH); i++) m.push_back(z);
    endfunction

    function automatic slot_t m_new(input bit v, input int s0, input int c0, input int c1);
        slot_t s;
        s = '{v: 1'b0, a: 0, w: 1'b0};
        if (v) begin
            s.v = 1'b1;
            if (s0 == 0)      s.a = c0;
            else if (s0 == 1) s.a = c1;
            else if (s0 == 2) s.a = int'(LINK);
            else              s.a = 0;
            s.w = (s0 != 3) && (s.a != 0);
        end
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_clear();
        end else if (!m[DEPTH-1].v || bus.wb_ready) begin
            slot_t ns;
            ns = m_new(bus.in_valid, int'(bus.S0), int'(bus.C0), int'(bus.C1));
            void'(m.pop_back());
            m.push_front(ns);
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        int occ;
        bit rsh, rth;
        occ = 0; rsh = 1'b0; rth = 1'b0;
        foreach (m[i]) begin
            if (m[i].v) occ++;
            if (m[i].v && m[i].w && m[i].a == int'(bus.rs_q) && bus.rs_q != 0) rsh = 1'b1;
            if (m[i].v && m[i].w && m[i].a == int'(bus.rt_q) && bus.rt_q != 0) rth = 1'b1;
        end
        chk("cmp_wb_valid",  32'(bus.wb_valid),  32'(m[DEPTH-1].v));
        chk("cmp_wb_addr",   32'(bus.wb_addr),   32'(m[DEPTH-1].a));
        chk("cmp_wb_we",     32'(bus.wb_we),     32'(m[DEPTH-1].w));
        chk("cmp_in_ready",  32'(bus.in_ready),  32'(!m[DEPTH-1].v || bus.wb_ready));
        chk("cmp_occupancy", 32'(bus.occupancy), 32'(occ));
        chk("cmp_rs_hazard", 32'(bus.rs_hazard), 32'(rsh));
        chk("cmp_rt_hazard", 32'(bus.rt_hazard), 32'(rth));
    end

    // Log of consumed entries as we*100+addr
    int got_q[$];
    always @(posedge clk) begin
        if (!rst && bus.wb_valid && bus.wb_ready)
            got_q.push_back(int'(bus.wb_we) * 100 + int'(bus.wb_addr));
    end

    task automatic check_log(input string nm, input int exp_q[$]);
        chk({nm, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) chk(nm, 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic drive(input bit v, input logic [1:0] s, input logic [4:0] c0,
                         input logic [4:0] c1, input bit rdy);
        bus.in_valid = v;
        bus.S0       = s;
        bus.C0       = c0;
        bus.C1       = c1;
        bus.wb_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_q[$];
        m_clear();
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b1);
        bus.rs_q = '0;
        bus.rt_q = '0;

        // Reset state
        #3;
        chk("rst_wb_valid",  32'(bus.wb_valid),  0);
        chk("rst_wb_addr",   32'(bus.wb_addr),   0);
        chk("rst_occupancy", 32'(bus.occupancy), 0);
        #9 rst = 1'b0;
        tick();

        // Single entry latency: rd=8
        got_q.delete();
        drive(1'b1, 2'b00, 5'd8, 5'd0, 1'b1);
        tick();
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b1);
        chk("lat_e1_valid", 32'(bus.wb_valid), 0);
        chk("lat_e1_occ",   32'(bus.occupancy), 1);
        tick();
        chk("lat_e2_valid", 32'(bus.wb_valid), 0);
        chk("lat_e2_occ",   32'(bus.occupancy), 1);
        tick();
        chk("lat_e3_valid", 32'(bus.wb_valid), 1);
        chk("lat_e3_addr",  32'(bus.wb_addr), 8);
        chk("lat_e3_we",    32'(bus.wb_we), 1);
        chk("lat_e3_occ",   32'(bus.occupancy), 1);
        tick();
        chk("lat_e4_valid", 32'(bus.wb_valid), 0);
        chk("lat_e4_occ",   32'(bus.occupancy), 0);
        exp_q = '{108};
        check_log("lat_log", exp_q);

        // Select coverage: rt=17, link, no-write, rd=0
        got_q.delete();
        drive(1'b1, 2'b01, 5'd3, 5'd17, 1'b1); tick();
        drive(1'b1, 2'b10, 5'd3, 5'd17, 1'b1); tick();
        drive(1'b1, 2'b11, 5'd5, 5'd17, 1'b1); tick();
        drive(1'b1, 2'b00, 5'd0, 5'd17, 1'b1); tick();
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("sel_rs0_hazard", 32'(bus.rs_hazard), 0);
            tick();
        end
        exp_q = '{117, 131, 0, 0};
        check_log("sel_log", exp_q);

        // Backpressure: 5,6,7 fill the pipe, 9 waits for in_ready
        got_q.delete();
        drive(1'b1, 2'b00, 5'd5, 5'd0, 1'b0); tick();
        drive(1'b1, 2'b00, 5'd6, 5'd0, 1'b0); tick();
        drive(1'b1, 2'b00, 5'd7, 5'd0, 1'b0); tick();
        drive(1'b1, 2'b00, 5'd9, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            chk("bp_occ",      32'(bus.occupancy), 3);
            chk("bp_wb_addr",  32'(bus.wb_addr), 5);
            tick();
        end
        bus.wb_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(bus.in_ready), 1);
        tick();
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b1);
        repeat (4) tick();
        exp_q = '{105, 106, 107, 109};
        check_log("bp_log", exp_q);

        // Hazard on dest 12 while in flight and stalled on wb_*
        bus.rs_q = 5'd12;
        bus.rt_q = 5'd13;
        drive(1'b1, 2'b00, 5'd12, 5'd0, 1'b0); tick();
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("hz_rs", 32'(bus.rs_hazard), 1);
            chk("hz_rt", 32'(bus.rt_hazard), 0);
            tick();
        end
        bus.wb_ready = 1'b1;
        #1 chk("hz_rs_before_consume", 32'(bus.rs_hazard), 1);
        tick();
        chk("hz_rs_after_consume", 32'(bus.rs_hazard), 0);
        chk("hz_valid_after",      32'(bus.wb_valid), 0);

        // Reset mid-stream with three entries in flight
        bus.rs_q = 5'd3;
        drive(1'b1, 2'b00, 5'd3, 5'd0, 1'b0); tick();
        drive(1'b1, 2'b00, 5'd4, 5'd0, 1'b0); tick();
        drive(1'b1, 2'b00, 5'd20, 5'd0, 1'b0); tick();
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        chk("mr_pre_occ", 32'(bus.occupancy), 3);
        #2 rst = 1'b1;
        #1;
        chk("mr_wb_valid", 32'(bus.wb_valid), 0);
        chk("mr_wb_addr",  32'(bus.wb_addr), 0);
        chk("mr_wb_we",    32'(bus.wb_we), 0);
        chk("mr_occ",      32'(bus.occupancy), 0);
        chk("mr_rs_haz",   32'(bus.rs_hazard), 0);
        #3 rst = 1'b0;
        tick();
        got_q.delete();
        bus.rs_q = '0;
        bus.rt_q = '0;
        drive(1'b1, 2'b00, 5'd22, 5'd0, 1'b1); tick();
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b1);
        chk("mr_new_e1_valid", 32'(bus.wb_valid), 0); tick();
        chk("mr_new_e2_valid", 32'(bus.wb_valid), 0); tick();
        chk("mr_new_e3_valid", 32'(bus.wb_valid), 1);
        chk("mr_new_e3_addr",  32'(bus.wb_addr), 22);
        tick();
        exp_q = '{122};
        check_log("mr_log", exp_q);

        // Back-to-back accept+emit at full occupancy
        got_q.delete();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 2'b00, 5'(i), 5'd0, 1'b1);
            tick();
            if (i >= 3) begin
                chk("b2b_occ",  32'(bus.occupancy), 3);
                chk("b2b_addr", 32'(bus.wb_addr), 32'(i - 2));
            end
        end
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b1);
        repeat (4) tick();
        exp_q = '{101, 102, 103, 104, 105, 106, 107, 108, 109, 110};
        check_log("b2b_log", exp_q);
        chk("b2b_final_occ", 32'(bus.occupancy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_dest_pipe.md
Name: wb_dest_pipe

Overview:
- Parametrised successor to the register-write-destination mux.
- Selects the register-file write address per instruction from rd, rt or the link register, or suppresses the write.
- Carries the selected address through a DEPTH-stage valid/ready pipeline to writeback.
- Continuously reports RAW hazards against in-flight destinations and the current pipeline occupancy; used by the multi-cycle/pipelined CPU variants between decode and writeback.

Parameters:
- ADDR_W, 5, register address width in bits.
- LINK_ADDR, 31, address selected for link writes (jal/jalr).
- DEPTH, 3, number of pipeline stages between accept and writeback output; legal range 1..8.
- CNT_W, 4, width of the occupancy count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents an instruction destination.
- in_ready  out  1  pipeline can accept this cycle.
- C0  in  ADDR_W  rd field.
- C1  in  ADDR_W  rt field.
- S0  in  2  select: 00 = rd, 01 = rt, 10 = LINK_ADDR, 11 = no write.
- wb_valid  out  1  output stage holds an entry.
- wb_ready  in  1  writeback consumes the entry.
- wb_addr  out  ADDR_W  selected destination.
- wb_we  out  1  register-file write enable for the entry.
- rs_q  in  ADDR_W  hazard query address A.
- rt_q  in  ADDR_W  hazard query address B.
- rs_hazard  out  1  A matches a pending write.
- rt_hazard  out  1  B matches a pending write.
- occupancy  out  CNT_W  count of valid stages.

Behaviour:
- Reset (asynchronous, immediate on rst rise) clears every stage valid, addr and we to 0.
  - While rst is high: wb_valid=0, wb_addr=0, wb_we=0, occupancy=0, rs_hazard=0, rt_hazard=0.
  - Reset mid-operation discards all in-flight entries; no partial writeback is emitted.
- Destination select is combinational at input and is registered into stage 0:
  - 00 → C0; 01 → C1; 10 → LINK_ADDR; 11 → addr 0 with we=0.
  - Any selected address equal to 0 forces we=0 ($zero is never written).
- Pipeline is a lockstep shift register; stage DEPTH-1 drives the wb_* outputs.
  - advance = !wb_valid || wb_ready.
  - in_ready = advance (combinational, no dependency on in_valid).
  - On advance, each stage k takes stage k-1 and stage 0 takes {in_valid, selected addr, we}. A cycle with in_valid=0 inserts a bubble.
  - On !advance, all stages hold their contents and the input is not accepted.
- Latency: an entry accepted at edge N appears on the wb_* outputs after edge N+DEPTH-1. This is DEPTH cycles of stage residency when there are no stalls.
- Ordering is strict FIFO; entries never reorder or duplicate. Bubbles are not collapsed during a stall.
- Throughput is one entry per cycle when wb_ready=1.
- Simultaneous accept and emit in the same cycle is legal; occupancy is unchanged in that case.
- Hazards (combinational from registered state):
  - rs_hazard = OR over stages of (valid & we & addr==rs_q), with rs_q==0 always yielding 0.
  - rt_hazard is the same for rt_q.
  - The current input (not yet accepted) is not included.
  - The entry on wb_* is included until the edge on which it is consumed.
- occupancy is the registered count of valid stages:
  - +1 on accept without emit; -1 on emit without accept.
  - Never exceeds DEPTH; never wraps.
- wb_addr and wb_we are 0 whenever wb_valid=0.

Test Plan:
- Reset, then DEPTH=3, wb_ready=1; send S0=00 with C0=8 for one cycle → wb_valid=1, wb_addr=8, wb_we=1 exactly 3 edges later; occupancy goes 1,1,1 then 0 after consume.
- Select coverage: S0=01 with C1=17 → addr 17, we=1; S0=10 → addr 31, we=1; S0=11 → we=0; S0=00 with C0=0 → we=0, rs_hazard never asserts for rs_q=0.
- Backpressure: stream 5,6,7,9 with wb_ready=0 → in_ready drops once wb_valid=1; occupancy saturates at 3; releasing wb_ready yields 5,6,7,9 in order with no loss or duplicate.
- Hazard: accept dest 12 → rs_q=12 gives rs_hazard=1 on every cycle while in flight, including while on wb_* stalled; clears the cycle after consume; rt_q=13 stays 0.
- Reset mid-stream: 3 entries in flight, pulse rst between edges → outputs zero immediately without a clock; after release, the first new entry emerges with the correct latency and no stale data.
- Back-to-back accept+emit at full occupancy with wb_ready=1 → occupancy stays 3 and outputs one entry per cycle.
